psum_tile_accumulator: RTL and testbench

Parametrised successor stage for the CNN accelerator datapath that removes the 256-input-channel limit: it sequences a layer's input channels in tiles of MAC_NUM, requests each tile from the control unit, and accumulates the per-lane partial sums of every tile. It then streams the final sums out as an AXI4-Stream master with full backpressure. It sits between the MAC array's psum output and the DMA/output stream, and reports progress through a status word readable over AXI-Lite.

---
 rtl/psum_tile_pkg.sv | 51 +++++
 rtl/psum_tile_accumulator_lane.sv | 44 ++++
 rtl/psum_tile_accumulator.sv | 170 +++++++++++++++++
 tb/tb_psum_tile_accumulator.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_tile_pkg.sv
// Shared types and helpers for the tiled psum accumulator: FSM states,
// status word layout and the saturating accumulate primitive.
package psum_tile_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_ACC,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_DONE_BIT  = 1;
    localparam int unsigned STAT_ERR_BIT   = 2;
    localparam int unsigned STAT_SAT_BIT   = 3;
    localparam int unsigned STAT_TILES_LSB = 4;
    localparam int unsigned STAT_IDX_LSB   = 16;
    localparam int unsigned STAT_FIELD_W   = 12;

    typedef struct packed {
        logic        sat;
        logic [63:0] sum;
    } sat_res_t;

    // Operands arrive sign-extended to 64 bits; the result is clamped to a
    // w-bit signed range and the caller truncates back to w bits.
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] s;
        sat_res_t           r;
        hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo    = -hi - 64'sd1;
        s     = a + b;
        r.sat = 1'b0;
        r.sum = s;
        if (s > hi) begin
            r.sum = hi;
            r.sat = 1'b1;
        end else if (s < lo) begin
            r.sum = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_tile_accumulator_lane.sv
// One output-channel accumulator: loads the first tile, then adds later
// tiles with saturation and keeps a sticky clamp flag.
module sat_acc_lane
    import psum_tile_pkg::*;
#(
    parameter int PSUM_W = 20,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     load,
    input  logic                     acc_en,
    input  logic signed [PSUM_W-1:0] psum,
    output logic signed [ACC_W-1:0]  acc,
    output logic                     sat
);

    sat_res_t res;

    always_comb begin
        res = sat_add(64'(acc), 64'(psum), ACC_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            sat <= 1'b0;
        end else begin
            if (clear) begin
                sat <= 1'b0;
            end
            if (load) begin
                acc <= ACC_W'(psum);
            end else if (acc_en) begin
                acc <= ACC_W'(res.sum);
                if (res.sat) begin
                    sat <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/psum_tile_accumulator.sv
// Tiled partial-sum accumulator: requests input-channel tiles, accumulates
// per-lane psums and drains the totals as an AXI4-Stream frame.
module psum_tile_accumulator
    import psum_tile_pkg::*;
#(
    parameter int MAC_NUM              = 256,
    parameter int LANES                = 64,
    parameter int PSUM_W               = 20,
    parameter int ACC_W                = 32,
    parameter int CH_W                 = 12,
    parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_start,
    input  logic [CH_W-1:0]                 cfg_input_channel_size,
    input  logic                            psum_valid,
    input  logic [LANES*PSUM_W-1:0]         psum_in,
    output logic                            psum_ready,
    output logic                            tile_req,
    output logic [CH_W-1:0]                 tile_idx,
    output logic                            M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                            M_AXIS_TLAST,
    input  logic                            M_AXIS_TREADY,
    output logic [31:0]                     status
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_t                   state;
    state_t                   state_n;
    logic [CH_W-1:0]          num_tiles;
    logic [CH_W-1:0]          tile_cnt;
    logic [CH_W-1:0]          tile_idx_q;
    logic [LANE_W-1:0]        lane_cnt;
    logic [LANES*PSUM_W-1:0]  psum_q;
    logic                     done_q;
    logic                     err_q;
    logic signed [ACC_W-1:0]  lane_acc [LANES];
    logic [LANES-1:0]         lane_sat;
    logic                     start_acc;
    logic                     beat;
    logic                     last_tile;
    logic                     last_lane;
    logic                     ch_zero;
    logic                     lane_load;
    logic                     lane_add;
    logic [31:0]              tiles_calc;

    always_comb begin
        ch_zero    = (cfg_input_channel_size == '0);
        start_acc  = (state == ST_IDLE) && cfg_start;
        beat       = (state == ST_DRAIN) && M_AXIS_TREADY;
        last_tile  = ((tile_idx_q + CH_W'(1)) == num_tiles);
        last_lane  = (lane_cnt == LANE_W'(LANES - 1));
        lane_load  = (state == ST_ACC) && (tile_idx_q == '0);
        lane_add   = (state == ST_ACC) && (tile_idx_q != '0);
        tiles_calc = (32'(cfg_input_channel_size) + 32'(MAC_NUM - 1)) / 32'(MAC_NUM);
    end

    // Stream outputs decode straight from registered state so TVALID never
    // depends on TREADY and the first beat is visible on entry to DRAIN.
    always_comb begin
        state_n       = state;
        psum_ready    = 1'b0;
        tile_req      = 1'b0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        M_AXIS_TDATA  = '0;
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_n = ch_zero ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                tile_req = 1'b1;
                state_n  = ST_WAIT;
            end
            ST_WAIT: begin
                psum_ready = 1'b1;
                if (psum_valid) begin
                    state_n = ST_ACC;
                end
            end
            ST_ACC: begin
                state_n = last_tile ? ST_DRAIN : ST_REQ;
            end
            ST_DRAIN: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TLAST  = last_lane;
                M_AXIS_TDATA  = C_M_AXIS_TDATA_WIDTH'(lane_acc[lane_cnt]);
                if (M_AXIS_TREADY && last_lane) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            num_tiles  <= '0;
            tile_cnt   <= '0;
            tile_idx_q <= '0;
            lane_cnt   <= '0;
            psum_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state <= state_n;
            if (start_acc) begin
                num_tiles  <= CH_W'(tiles_calc);
                tile_cnt   <= '0;
                tile_idx_q <= '0;
                done_q     <= 1'b0;
                err_q      <= ch_zero;
            end
            if ((state == ST_WAIT) && psum_valid) begin
                psum_q <= psum_in;
            end
            if (state == ST_ACC) begin
                tile_cnt   <= tile_cnt + CH_W'(1);
                tile_idx_q <= tile_idx_q + CH_W'(1);
                lane_cnt   <= '0;
            end
            if (beat) begin
                lane_cnt <= lane_cnt + LANE_W'(1);
            end
            if ((state_n == ST_DONE) && (state != ST_DONE)) begin
                done_q <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sat_acc_lane #(
            .PSUM_W(PSUM_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clear (start_acc),
            .load  (lane_load),
            .acc_en(lane_add),
            .psum  (psum_q[i*PSUM_W +: PSUM_W]),
            .acc   (lane_acc[i]),
            .sat   (lane_sat[i])
        );
    end

    always_comb begin
        tile_idx                                     = tile_idx_q;
        status                                       = '0;
        status[STAT_BUSY_BIT]                        = (state != ST_IDLE);
        status[STAT_DONE_BIT]                        = done_q;
        status[STAT_ERR_BIT]                         = err_q;
        status[STAT_SAT_BIT]                         = |lane_sat;
        status[STAT_TILES_LSB +: STAT_FIELD_W]       = STAT_FIELD_W'(tile_cnt);
        status[STAT_IDX_LSB +: STAT_FIELD_W]         = STAT_FIELD_W'(tile_idx_q);
    end

endmodule

// File: tb/tb_psum_tile_accumulator.sv
// Directed bench for psum_tile_accumulator: a default instance and an
// ACC_W=20 instance run in lockstep on shared stimulus.
module tb_psum_tile_accumulator;

    localparam int LANES  = 64;
    localparam int PSUM_W = 20;
    localparam int CH_W   = 12;
    localparam int DW     = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cfg_start;
    logic [CH_W-1:0]         ch;
    logic                    psum_valid;
    logic [LANES*PSUM_W-1:0] psum_in;
    logic                    tready;

    logic            a_ready, a_req, a_tvalid, a_tlast;
    logic [CH_W-1:0] a_idx;
    logic [DW-1:0]   a_tdata;
    logic [31:0]     a_status;
    logic            b_ready, b_req, b_tvalid, b_tlast;
    logic [CH_W-1:0] b_idx;
    logic [DW-1:0]   b_tdata;
    logic [31:0]     b_status;

    int          errors = 0;
    int          checks = 0;
    int          cyc;
    logic [31:0] exp_a [LANES];
    logic [31:0] exp_b [LANES];

    always #5 clk = ~clk;

    psum_tile_accumulator u_dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_input_channel_size(ch),
        .psum_valid(psum_valid), .psum_in(psum_in), .psum_ready(a_ready),
        .tile_req(a_req), .tile_idx(a_idx), .M_AXIS_TVALID(a_tvalid),
        .M_AXIS_TDATA(a_tdata), .M_AXIS_TLAST(a_tlast), .M_AXIS_TREADY(tready),
        .status(a_status)
    );

    psum_tile_accumulator #(.ACC_W(20)) u_sat (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_input_channel_size(ch),
        .psum_valid(psum_valid), .psum_in(psum_in), .psum_ready(b_ready),
        .tile_req(b_req), .tile_idx(b_idx), .M_AXIS_TVALID(b_tvalid),
        .M_AXIS_TDATA(b_tdata), .M_AXIS_TLAST(b_tlast), .M_AXIS_TREADY(tready),
        .status(b_status)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input int val);
        for (int i = 0; i < LANES; i++) psum_in[i*PSUM_W +: PSUM_W] = 20'(val);
    endtask

    task automatic set_lin(input int mult);
        for (int i = 0; i < LANES; i++) psum_in[i*PSUM_W +: PSUM_W] = 20'(mult * i);
    endtask

    task automatic do_start(input int c);
        ch        = CH_W'(c);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // Entered at the sample where tile_req should be high; leaves at the
    // sample two cycles after the handshake (next REQ or first beat).
    task automatic serve_tile(input int idx);
        check("tile_req", a_req, 1);
        check("tile_idx", a_idx, idx);
        check("sat_tile_req", b_req, 1);
        psum_valid = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("psum_ready_wait", a_ready, 1);
        check("tile_req_pulse", a_req, 0);
        tick();
        psum_valid = 1'b0;
        check("psum_ready_acc", a_ready, 0);
        tick();
    endtask

    task automatic drain(input int n, input bit rnd, output int cycles);
        int          beat;
        bit          stalled;
        logic [31:0] held;
        logic        held_last;
        beat    = 0;
        stalled = 1'b0;
        cycles  = 0;
        while (beat < n && cycles < 2000) begin
            if (stalled) begin
                check("stall_valid", a_tvalid, 1);
                check("stall_data", a_tdata, held);
                check("stall_last", a_tlast, held_last);
            end
            tready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (a_tvalid && tready) begin
                check("beat_data", a_tdata, exp_a[beat]);
                check("beat_last", a_tlast, (beat == LANES - 1));
                check("sat_beat_data", b_tdata, exp_b[beat]);
                beat++;
                stalled = 1'b0;
            end else begin
                stalled   = a_tvalid;
                held      = a_tdata;
                held_last = a_tlast;
            end
            tick();
            cycles++;
        end
        if (beat < n) check("drain_timeout", beat, n);
        tready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        cfg_start  = 1'b0;
        ch         = '0;
        psum_valid = 1'b0;
        psum_in    = '0;
        tready     = 1'b0;
        tick();
        tick();
        check("rst_ready", a_ready, 0);
        check("rst_req", a_req, 0);
        check("rst_tvalid", a_tvalid, 0);
        check("rst_tlast", a_tlast, 0);
        check("rst_tdata", a_tdata, 0);
        check("rst_idx", a_idx, 0);
        check("rst_status", a_status, 0);
        check("rst_sat_status", b_status, 0);
        rst = 1'b0;
        tick();

        // Single tile of 5s at full rate; a start during REQ must be ignored.
        set_all(5);
        for (int i = 0; i < LANES; i++) begin
            exp_a[i] = 32'd5;
            exp_b[i] = 32'd5;
        end
        do_start(256);
        cfg_start = 1'b1;
        ch        = '0;
        serve_tile(0);
        check("t1_first_tvalid", a_tvalid, 1);
        drain(LANES, 1'b0, cyc);
        check("t1_full_rate_cycles", cyc, LANES);
        check("t1_done_tvalid", a_tvalid, 0);
        check("t1_done_tlast", a_tlast, 0);
        check("t1_done_status", a_status, 32'h0001_0013);
        tick();
        check("t1_idle_status", a_status, 32'h0001_0012);
        check("t1_sat_idle_status", b_status, 32'h0001_0012);

        // Three tiles (i, -i, 2i) drained under random backpressure.
        for (int i = 0; i < LANES; i++) begin
            exp_a[i] = 32'(2 * i);
            exp_b[i] = 32'(2 * i);
        end
        set_lin(1);
        do_start(600);
        serve_tile(0);
        set_lin(-1);
        serve_tile(1);
        set_lin(2);
        serve_tile(2);
        check("t2_first_tvalid", a_tvalid, 1);
        check("t2_no_req", a_req, 0);
        drain(LANES, 1'b1, cyc);
        check("t2_done_status", a_status, 32'h0003_0033);
        check("t2_done_tvalid", a_tvalid, 0);
        tick();
        check("t2_idle_status", a_status, 32'h0003_0032);

        // Two tiles of max positive psum: fits in 32 bits, clamps in 20.
        set_all(20'h7FFFF);
        for (int i = 0; i < LANES; i++) begin
            exp_a[i] = 32'h000F_FFFE;
            exp_b[i] = 32'h0007_FFFF;
        end
        do_start(512);
        serve_tile(0);
        serve_tile(1);
        drain(LANES, 1'b0, cyc);
        check("t3_done_status", a_status, 32'h0002_0023);
        check("t3_sat_done_status", b_status, 32'h0002_002B);
        tick();

        // Zero channels: error, no tile request, done immediately.
        do_start(0);
        check("t5_no_req", a_req, 0);
        check("t5_no_tvalid", a_tvalid, 0);
        check("t5_done_status", a_status, 32'h0000_0007);
        tick();
        check("t5_no_req2", a_req, 0);
        check("t5_idle_status", a_status, 32'h0000_0006);

        // Reset after ten beats, then a complete fresh frame.
        set_lin(3);
        for (int i = 0; i < LANES; i++) begin
            exp_a[i] = 32'(3 * i);
            exp_b[i] = 32'(3 * i);
        end
        do_start(256);
        serve_tile(0);
        drain(10, 1'b0, cyc);
        check("t6_mid_tvalid", a_tvalid, 1);
        rst = 1'b1;
        tick();
        check("t6_rst_tvalid", a_tvalid, 0);
        check("t6_rst_tlast", a_tlast, 0);
        check("t6_rst_tdata", a_tdata, 0);
        check("t6_rst_status", a_status, 0);
        check("t6_rst_sat_tvalid", b_tvalid, 0);
        rst = 1'b0;
        tick();
        do_start(256);
        serve_tile(0);
        drain(LANES, 1'b0, cyc);
        check("t6_fresh_cycles", cyc, LANES);
        check("t6_fresh_status", a_status, 32'h0001_0013);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
